// File: rtl/alu_arbiter_if.sv
// Bundles the request, response and ALU-side signals of alu_arbiter.
//   master : requester/environment side (drives requests, response ready, ALU results)
//   slave  : arbiter side (drives request ready, response, ALU operands)
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CTRL_W = 4;

  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic              rsp_zero;

  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_out, alu_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_out, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU evaluates registered
// operands) -> RESP (result held until the owner consumes it).
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : alu_arbiter_if.slave (req0/req1, rsp0/rsp1, ALU operands/result)
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic              owner;
  logic              grant;
  logic              accept;
  logic [WIDTH-1:0]  alu_a_q;
  logic [WIDTH-1:0]  alu_b_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_zero_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic              owner_rsp_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection and next-state logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    // Tie goes to the port that was not served last; otherwise the lone requester.
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = bus.req1_valid;
    end
    owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;
    case (state)
      IDLE: begin
        if (!reset && (bus.req0_valid || bus.req1_valid)) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (owner_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, result capture and response valids
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        alu_a_q    <= grant ? bus.req1_a    : bus.req0_a;
        alu_b_q    <= grant ? bus.req1_b    : bus.req0_b;
        alu_ctrl_q <= grant ? bus.req1_ctrl : bus.req0_ctrl;
      end
      if (state == EXEC) begin
        rsp_data_q   <= bus.alu_out;
        rsp_zero_q   <= bus.alu_zero;
        rsp0_valid_q <= ~owner;
        rsp1_valid_q <= owner;
      end else if (state == RESP && owner_rsp_ready) begin
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  // Request ready is a same-cycle grant indication
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_ctrl   = alu_ctrl_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table plus hand-written
// sequences for tie arbitration, response back-pressure and mid-op reset.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA, others 0
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    case (bus.alu_ctrl)
      4'd0:    alu_res = bus.alu_a + bus.alu_b;
      4'd1:    alu_res = bus.alu_a - bus.alu_b;
      4'd2:    alu_res = bus.alu_a & bus.alu_b;
      4'd3:    alu_res = bus.alu_a | bus.alu_b;
      4'd4:    alu_res = bus.alu_a ^ bus.alu_b;
      4'd5:    alu_res = {31'b0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      4'd6:    alu_res = {31'b0, (bus.alu_a < bus.alu_b)};
      4'd7:    alu_res = bus.alu_a << bus.alu_b[4:0];
      4'd8:    alu_res = bus.alu_a >> bus.alu_b[4:0];
      4'd9:    alu_res = 32'($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_out  = alu_res;
  assign bus.alu_zero = (alu_res == '0);

  typedef struct {
    string       name;
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input int port, input logic valid, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] ctrl);
    if (port == 0) begin
      bus.req0_valid = valid; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl;
    end else begin
      bus.req1_valid = valid; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl;
    end
  endtask

  // Called at a falling edge; returns granted port or -1 after the budget expires.
  task automatic wait_grant(input string name, output int port);
    port = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) begin
        check({name, "_one_ready"}, 32'd2, 32'd1);
      end
      if (bus.req0_ready || bus.req1_ready) begin
        port = bus.req1_ready ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (port < 0) check({name, "_grant_timeout"}, 32'hFFFF_FFFF, 32'd0);
  endtask

  // One complete operation from a single requester, response consumed at once.
  task automatic run_op(input vec_t v);
    int g;
    set_req(v.port, 1'b1, v.a, v.b, v.ctrl);
    wait_grant(v.name, g);
    if (g < 0) begin
      set_req(v.port, 1'b0, v.a, v.b, v.ctrl);
      return;
    end
    check({v.name, "_grant"}, 32'(g), 32'(v.port));
    @(posedge clk);
    @(negedge clk);
    set_req(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check({v.name, "_exec_rsp0"}, 32'(bus.rsp0_valid), 32'd0);
    check({v.name, "_exec_rsp1"}, 32'(bus.rsp1_valid), 32'd0);
    @(negedge clk);
    #1;
    check({v.name, "_rsp0_valid"}, 32'(bus.rsp0_valid), (v.port == 0) ? 32'd1 : 32'd0);
    check({v.name, "_rsp1_valid"}, 32'(bus.rsp1_valid), (v.port == 1) ? 32'd1 : 32'd0);
    check({v.name, "_data"}, bus.rsp_data, v.exp_data);
    check({v.name, "_zero"}, 32'(bus.rsp_zero), 32'(v.exp_zero));
    if (v.port == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check({v.name, "_rsp_done"}, 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    check({v.name, "_opnd_hold"}, bus.alu_a, v.a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int g;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    vecs[0] = '{"add0",  0, 32'd5,          32'd7,    4'b0000, 32'd12,         1'b0};
    vecs[1] = '{"sub1",  1, 32'd9,          32'd9,    4'b0001, 32'd0,          1'b1};
    vecs[2] = '{"sra1",  1, 32'h8000_0000,  32'd4,    4'b1001, 32'hF800_0000,  1'b0};
    vecs[3] = '{"ill1",  1, 32'h1234,       32'h5678, 4'b1111, 32'd0,          1'b1};
    vecs[4] = '{"xor0",  0, 32'hFF,         32'h0F,   4'b0100, 32'hF0,         1'b0};
    vecs[5] = '{"sltu0", 0, 32'hFFFF_FFFF,  32'd1,    4'b0110, 32'd0,          1'b1};
    vecs[6] = '{"slt1",  1, 32'hFFFF_FFFF,  32'd1,    4'b0101, 32'd1,          1'b0};
    vecs[7] = '{"sll0",  0, 32'd1,          32'd31,   4'b0111, 32'h8000_0000,  1'b0};

    // Reset values, with a request pending while reset is held
    @(negedge clk);
    bus.req0_valid = 1'b1;
    #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_rsp_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed single-requester vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i]);
    end

    // Tie after reset: port 0 first, then strict alternation over 6 ops
    do_reset();
    set_req(0, 1'b1, 32'hF0F0, 32'hFF00, 4'b0010);
    set_req(1, 1'b1, 32'd1, 32'd2, 4'b0011);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_grant("tie", g);
      if (g < 0) break;
      check($sformatf("tie_grant%0d", i), 32'(g), 32'(i % 2));
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      check($sformatf("tie_data%0d", i), bus.rsp_data, (i % 2 == 0) ? 32'h0000_F000 : 32'd3);
      @(negedge clk);
    end
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);

    // Response back-pressure: RESP held 4 cycles while req1 waits
    set_req(0, 1'b1, 32'd20, 32'd22, 4'b0000);
    wait_grant("bp", g);
    check("bp_grant", 32'(g), 32'd0);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'd1, 32'd2, 4'b0011);
    #1;
    check("bp_exec_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("bp_rsp0_valid%0d", c), 32'(bus.rsp0_valid), 32'd1);
      check($sformatf("bp_data%0d", c), bus.rsp_data, 32'd42);
      check($sformatf("bp_req1_ready%0d", c), 32'(bus.req1_ready), 32'd0);
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b1;
    #1;
    check("bp_req1_ready_last", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("bp_rsp0_dropped", 32'(bus.rsp0_valid), 32'd0);
    check("bp_req1_granted", 32'(bus.req1_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1;
    check("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("bp_rsp1_data", bus.rsp_data, 32'd3);
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;

    // Reset during EXEC discards the operation
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0101);
    wait_grant("mid", g);
    check("mid_grant", 32'(g), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("mid_alu_a", bus.alu_a, 32'd0);
    check("mid_rsp0", 32'(bus.rsp0_valid), 32'd0);
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.rsp0_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("mid_no_rsp%0d", c), 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
      @(negedge clk);
    end
    run_op(vecs[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
